// File: rtl/ppg_window_stats.sv
// ppg_window_stats: splits the multiplexed PPG ADC stream into IR and RED
// channels, drops settling samples after LED switches or front-end config
// changes, and reports per-window AC (max-min), DC (mean) and saturation.
module ppg_window_stats #(
  parameter int WIN_LOG2 = 6,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] ADC,
  input  logic       LED_IR,
  input  logic       LED_RED,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] ir_ac,
  output logic [7:0] ir_dc,
  output logic       ir_sat,
  output logic       ir_valid,
  output logic [7:0] red_ac,
  output logic [7:0] red_dc,
  output logic       red_sat,
  output logic       red_valid
);

  localparam int SUM_W = 8 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM} state_t;
  typedef enum logic [1:0] {CH_NONE, CH_IR, CH_RED} chan_t;

  state_t state_q, state_d;
  chan_t  chan_q, chan_d, dec_chan;
  logic [3:0] settle_q, settle_d, settle_eff;
  logic [6:0] dc_comp_q;
  logic [3:0] pga_gain_q;

  // Index 0 holds the IR channel, index 1 the RED channel.
  logic [7:0]       min_q [2];
  logic [7:0]       min_d [2];
  logic [7:0]       max_q [2];
  logic [7:0]       max_d [2];
  logic [SUM_W-1:0] sum_q [2];
  logic [SUM_W-1:0] sum_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             sat_q [2];
  logic             sat_d [2];
  logic [7:0]       ac_q [2];
  logic [7:0]       ac_d [2];
  logic [7:0]       dc_q [2];
  logic [7:0]       dc_d [2];
  logic             sat_out_q [2];
  logic             sat_out_d [2];
  logic             valid_q [2];
  logic             valid_d [2];

  logic             cfg_change, strobe, chan_switch;
  logic             accept, clear_all, acc_sel;
  logic [7:0]       min_n, max_n;
  logic [SUM_W-1:0] sum_n;
  logic             sat_n;

  // Decode the LED selects and detect switches / front-end reconfiguration.
  always_comb begin
    dec_chan = CH_NONE;
    if (LED_IR && !LED_RED) begin
      dec_chan = CH_IR;
    end else if (LED_RED && !LED_IR) begin
      dec_chan = CH_RED;
    end
    cfg_change  = (DC_Comp != dc_comp_q) || (PGA_Gain != pga_gain_q);
    strobe      = sample_valid && (dec_chan != CH_NONE);
    chan_switch = strobe && (chan_q != CH_NONE) && (dec_chan != chan_q);
    // A switch reloads the settle count before this strobe is judged, so the
    // switching sample itself becomes the first discard.
    settle_eff  = chan_switch ? SETTLE_C : settle_q;
    acc_sel     = (dec_chan == CH_RED);
  end

  // Control FSM: decide whether this strobe is discarded or accepted.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    chan_d    = chan_q;
    accept    = 1'b0;
    clear_all = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      settle_d  = SETTLE_C;
      chan_d    = CH_NONE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_SETTLE;
          settle_d  = SETTLE_C;
          clear_all = 1'b1;
        end
        default: begin
          if (cfg_change) begin
            clear_all = 1'b1;
            settle_d  = SETTLE_C;
            state_d   = ST_SETTLE;
          end else if (strobe) begin
            chan_d = dec_chan;
            if (settle_eff == 4'd0) begin
              accept   = 1'b1;
              settle_d = 4'd0;
              state_d  = ST_ACCUM;
            end else begin
              settle_d = settle_eff - 4'd1;
              state_d  = ST_SETTLE;
            end
          end
        end
      endcase
    end
  end

  // Window datapath: fold accepted samples in and publish finished windows.
  always_comb begin
    min_n = (ADC < min_q[acc_sel]) ? ADC : min_q[acc_sel];
    max_n = (ADC > max_q[acc_sel]) ? ADC : max_q[acc_sel];
    sum_n = sum_q[acc_sel] + SUM_W'(ADC);
    sat_n = sat_q[acc_sel] || (ADC == 8'd0) || (ADC == 8'd255);
    for (int c = 0; c < 2; c++) begin
      min_d[c]     = min_q[c];
      max_d[c]     = max_q[c];
      sum_d[c]     = sum_q[c];
      cnt_d[c]     = cnt_q[c];
      sat_d[c]     = sat_q[c];
      ac_d[c]      = ac_q[c];
      dc_d[c]      = dc_q[c];
      sat_out_d[c] = sat_out_q[c];
      valid_d[c]   = 1'b0;
      if (clear_all) begin
        min_d[c] = 8'hFF;
        max_d[c] = 8'h00;
        sum_d[c] = '0;
        cnt_d[c] = '0;
        sat_d[c] = 1'b0;
      end else if (accept && (acc_sel == 1'(c))) begin
        if (cnt_q[c] == CNT_LAST) begin
          ac_d[c]      = max_n - min_n;
          dc_d[c]      = 8'(sum_n >> WIN_LOG2);
          sat_out_d[c] = sat_n;
          valid_d[c]   = 1'b1;
          min_d[c]     = 8'hFF;
          max_d[c]     = 8'h00;
          sum_d[c]     = '0;
          cnt_d[c]     = '0;
          sat_d[c]     = 1'b0;
        end else begin
          min_d[c] = min_n;
          max_d[c] = max_n;
          sum_d[c] = sum_n;
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
          sat_d[c] = sat_n;
        end
      end
    end
  end

  // State, accumulator and result registers; async reset wipes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      chan_q     <= CH_NONE;
      settle_q   <= SETTLE_C;
      dc_comp_q  <= '0;
      pga_gain_q <= '0;
      for (int c = 0; c < 2; c++) begin
        min_q[c]     <= 8'hFF;
        max_q[c]     <= 8'h00;
        sum_q[c]     <= '0;
        cnt_q[c]     <= '0;
        sat_q[c]     <= 1'b0;
        ac_q[c]      <= 8'h00;
        dc_q[c]      <= 8'h00;
        sat_out_q[c] <= 1'b0;
        valid_q[c]   <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      settle_q   <= settle_d;
      dc_comp_q  <= DC_Comp;
      pga_gain_q <= PGA_Gain;
      for (int c = 0; c < 2; c++) begin
        min_q[c]     <= min_d[c];
        max_q[c]     <= max_d[c];
        sum_q[c]     <= sum_d[c];
        cnt_q[c]     <= cnt_d[c];
        sat_q[c]     <= sat_d[c];
        ac_q[c]      <= ac_d[c];
        dc_q[c]      <= dc_d[c];
        sat_out_q[c] <= sat_out_d[c];
        valid_q[c]   <= valid_d[c];
      end
    end
  end

  assign ir_ac     = ac_q[0];
  assign ir_dc     = dc_q[0];
  assign ir_sat    = sat_out_q[0];
  assign ir_valid  = valid_q[0];
  assign red_ac    = ac_q[1];
  assign red_dc    = dc_q[1];
  assign red_sat   = sat_out_q[1];
  assign red_valid = valid_q[1];

endmodule

// File: tb/tb_ppg_window_stats.sv
// tb_ppg_window_stats: three instances (SETTLE=0,1,2, window of 4) share one
// stimulus stream; a window-level model is compared every cycle and directed
// literal checks pin the headline scenarios.
module tb_ppg_window_stats;

  localparam int N = 4;

  logic       clk, rst_n, enable, sample_valid;
  logic [7:0] ADC;
  logic       LED_IR, LED_RED;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;

  logic [7:0] ir_ac [3];
  logic [7:0] ir_dc [3];
  logic       ir_sat [3];
  logic       ir_valid [3];
  logic [7:0] red_ac [3];
  logic [7:0] red_dc [3];
  logic       red_sat [3];
  logic       red_valid [3];

  int checks = 0;
  int failures = 0;

  // Instance k is built with SETTLE=k.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ppg_window_stats #(.WIN_LOG2(2), .SETTLE(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
      .ADC(ADC), .LED_IR(LED_IR), .LED_RED(LED_RED),
      .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
      .ir_ac(ir_ac[g]), .ir_dc(ir_dc[g]), .ir_sat(ir_sat[g]), .ir_valid(ir_valid[g]),
      .red_ac(red_ac[g]), .red_dc(red_dc[g]), .red_sat(red_sat[g]), .red_valid(red_valid[g])
    );
  end

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: collected window samples per instance and channel.
  logic [7:0]  mwin [3][2][N];
  int          mcnt [3][2];
  int          mskip [3];
  int          mlast [3];
  bit          mactive [3];
  logic [10:0] mcfg;
  logic [7:0]  e_ac [3][2];
  logic [7:0]  e_dc [3][2];
  logic        e_sat [3][2];
  logic        e_val [3][2];
  int          m_ch, m_sum;
  bit          m_chg;
  logic [7:0]  m_mx, m_mn;
  logic        m_sat;

  // Reference model: channel/settle rules applied to whole-window sample lists.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcfg = '0;
      for (int k = 0; k < 3; k++) begin
        mskip[k] = k;
        mlast[k] = -1;
        mactive[k] = 0;
        for (int c = 0; c < 2; c++) begin
          mcnt[k][c] = 0;
          e_ac[k][c] = 0; e_dc[k][c] = 0; e_sat[k][c] = 0; e_val[k][c] = 0;
        end
      end
    end else begin
      m_chg = ({DC_Comp, PGA_Gain} != mcfg);
      mcfg = {DC_Comp, PGA_Gain};
      m_ch = (LED_IR && !LED_RED) ? 0 : ((LED_RED && !LED_IR) ? 1 : -1);
      for (int k = 0; k < 3; k++) begin
        e_val[k][0] = 0;
        e_val[k][1] = 0;
        if (!enable) begin
          mactive[k] = 0;
          mcnt[k][0] = 0; mcnt[k][1] = 0;
          mskip[k] = k;
          mlast[k] = -1;
        end else if (!mactive[k]) begin
          mactive[k] = 1;
        end else if (m_chg) begin
          mcnt[k][0] = 0; mcnt[k][1] = 0;
          mskip[k] = k;
        end else if (sample_valid && m_ch >= 0) begin
          if (mlast[k] >= 0 && m_ch != mlast[k]) mskip[k] = k;
          mlast[k] = m_ch;
          if (mskip[k] > 0) begin
            mskip[k]--;
          end else begin
            mwin[k][m_ch][mcnt[k][m_ch]] = ADC;
            mcnt[k][m_ch]++;
            if (mcnt[k][m_ch] == N) begin
              m_mx = 0; m_mn = 255; m_sum = 0; m_sat = 0;
              for (int i = 0; i < N; i++) begin
                if (mwin[k][m_ch][i] > m_mx) m_mx = mwin[k][m_ch][i];
                if (mwin[k][m_ch][i] < m_mn) m_mn = mwin[k][m_ch][i];
                m_sum += int'(mwin[k][m_ch][i]);
                if (mwin[k][m_ch][i] == 0 || mwin[k][m_ch][i] == 255) m_sat = 1;
              end
              e_ac[k][m_ch] = m_mx - m_mn;
              e_dc[k][m_ch] = 8'(m_sum / N);
              e_sat[k][m_ch] = m_sat;
              e_val[k][m_ch] = 1;
              mcnt[k][m_ch] = 0;
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("dut%0d_outputs", k),
        {ir_ac[k], ir_dc[k], ir_sat[k], ir_valid[k], red_ac[k], red_dc[k], red_sat[k], red_valid[k]},
        {e_ac[k][0], e_dc[k][0], e_sat[k][0], e_val[k][0], e_ac[k][1], e_dc[k][1], e_sat[k][1], e_val[k][1]});
    end
  end

  task automatic applyStimulus(input logic ir, input logic red, input logic [7:0] adc, input logic [3:0] gain);
    @(negedge clk);
    LED_IR = ir; LED_RED = red; ADC = adc; PGA_Gain = gain; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic irStrobe(input logic [7:0] adc);
    applyStimulus(1'b1, 1'b0, adc, PGA_Gain);
  endtask

  task automatic redStrobe(input logic [7:0] adc);
    applyStimulus(1'b0, 1'b1, adc, PGA_Gain);
  endtask

  task automatic releaseReset();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    enable = 1'b0; sample_valid = 1'b0; PGA_Gain = 4'd3; DC_Comp = 7'd5;
    releaseReset();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; ADC = 8'd0;
    LED_IR = 1'b0; LED_RED = 1'b0; DC_Comp = 7'd5; PGA_Gain = 4'd3;
    @(negedge clk);
    checkOutput("reset_ir_dc", 36'(ir_dc[0]), 36'd0);
    checkOutput("reset_red_dc", 36'(red_dc[2]), 36'd0);
    releaseReset();

    $display("[TB] basic window, SETTLE=0");
    irStrobe(8'd10); irStrobe(8'd50); irStrobe(8'd30);
    checkOutput("t1_no_valid_early", 36'(ir_valid[0]), 36'd0);
    irStrobe(8'd20);
    checkOutput("t1_ir_valid", 36'(ir_valid[0]), 36'd1);
    checkOutput("t1_ir_ac", 36'(ir_ac[0]), 36'd40);
    checkOutput("t1_ir_dc", 36'(ir_dc[0]), 36'd27);
    checkOutput("t1_ir_sat", 36'(ir_sat[0]), 36'd0);
    checkOutput("t1_red_dc", 36'(red_dc[0]), 36'd0);
    checkOutput("t1_red_valid", 36'(red_valid[0]), 36'd0);
    @(negedge clk);
    checkOutput("t1_valid_one_cycle", 36'(ir_valid[0]), 36'd0);
    checkOutput("t1_ir_ac_hold", 36'(ir_ac[0]), 36'd40);

    $display("[TB] settle discards, SETTLE=2");
    doReset();
    for (int i = 0; i < 5; i++) begin
      irStrobe(8'd100);
      checkOutput($sformatf("t2_no_valid_%0d", i + 1), 36'(ir_valid[2]), 36'd0);
    end
    irStrobe(8'd100);
    checkOutput("t2_ir_valid", 36'(ir_valid[2]), 36'd1);
    checkOutput("t2_ir_dc", 36'(ir_dc[2]), 36'd100);
    checkOutput("t2_ir_ac", 36'(ir_ac[2]), 36'd0);

    $display("[TB] interleaved channels, SETTLE=1");
    doReset();
    irStrobe(8'd10); irStrobe(8'd20); irStrobe(8'd40);
    for (int i = 0; i < 4; i++) redStrobe(8'd200);
    checkOutput("t3_red_not_yet", 36'(red_valid[1]), 36'd0);
    redStrobe(8'd200);
    checkOutput("t3_red_valid", 36'(red_valid[1]), 36'd1);
    checkOutput("t3_red_dc", 36'(red_dc[1]), 36'd200);
    checkOutput("t3_ir_not_valid", 36'(ir_valid[1]), 36'd0);
    irStrobe(8'd7); irStrobe(8'd60);
    checkOutput("t3_ir_not_yet", 36'(ir_valid[1]), 36'd0);
    irStrobe(8'd80);
    checkOutput("t3_ir_valid", 36'(ir_valid[1]), 36'd1);
    checkOutput("t3_ir_dc", 36'(ir_dc[1]), 36'd50);
    checkOutput("t3_ir_ac", 36'(ir_ac[1]), 36'd60);

    $display("[TB] gain change on completing strobe, SETTLE=0");
    doReset();
    irStrobe(8'd10); irStrobe(8'd20); irStrobe(8'd30);
    applyStimulus(1'b1, 1'b0, 8'd40, 4'd4);
    checkOutput("t4_cfg_wins", 36'(ir_valid[0]), 36'd0);
    irStrobe(8'd50); irStrobe(8'd60); irStrobe(8'd70);
    checkOutput("t4_restart_not_yet", 36'(ir_valid[0]), 36'd0);
    irStrobe(8'd80);
    checkOutput("t4_ir_valid", 36'(ir_valid[0]), 36'd1);
    checkOutput("t4_ir_dc", 36'(ir_dc[0]), 36'd65);
    checkOutput("t4_ir_ac", 36'(ir_ac[0]), 36'd30);

    $display("[TB] saturation flag, SETTLE=0");
    doReset();
    irStrobe(8'd255); irStrobe(8'd10); irStrobe(8'd10); irStrobe(8'd10);
    checkOutput("t5_sat", 36'(ir_sat[0]), 36'd1);
    checkOutput("t5_ac", 36'(ir_ac[0]), 36'd245);
    checkOutput("t5_dc", 36'(ir_dc[0]), 36'd71);
    for (int i = 0; i < 4; i++) irStrobe(8'd20);
    checkOutput("t5_clean_sat", 36'(ir_sat[0]), 36'd0);
    checkOutput("t5_clean_dc", 36'(ir_dc[0]), 36'd20);

    $display("[TB] invalid LED strobes and mid-window reset, SETTLE=0");
    doReset();
    irStrobe(8'd10);
    applyStimulus(1'b1, 1'b1, 8'd0, PGA_Gain);
    irStrobe(8'd20); irStrobe(8'd30);
    checkOutput("t6_both_ignored", 36'(ir_valid[0]), 36'd0);
    irStrobe(8'd40);
    checkOutput("t6_valid", 36'(ir_valid[0]), 36'd1);
    checkOutput("t6_dc", 36'(ir_dc[0]), 36'd25);
    checkOutput("t6_sat", 36'(ir_sat[0]), 36'd0);
    irStrobe(8'd100); irStrobe(8'd100); irStrobe(8'd100);
    applyStimulus(1'b1, 1'b1, 8'd255, PGA_Gain);
    @(negedge clk);
    #3 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("t6_async_ir_dc", 36'(ir_dc[0]), 36'd0);
    checkOutput("t6_async_ir_ac", 36'(ir_ac[0]), 36'd0);
    checkOutput("t6_async_ir_sat", 36'(ir_sat[0]), 36'd0);
    releaseReset();
    applyStimulus(1'b0, 1'b0, 8'd0, PGA_Gain);
    irStrobe(8'd40); irStrobe(8'd40); irStrobe(8'd40);
    checkOutput("t6_fresh_window", 36'(ir_valid[0]), 36'd0);
    irStrobe(8'd40);
    checkOutput("t6_post_valid", 36'(ir_valid[0]), 36'd1);
    checkOutput("t6_post_dc", 36'(ir_dc[0]), 36'd40);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
